// File: rtl/vmcmp_pkg.sv
// vmcmp_pkg: shared encodings for the vALU mask-compare pack unit.
// SEW codes, compare opcodes, the pack FSM state type and the
// elements-per-beat helper used by the top level.
package vmcmp_pkg;

  localparam logic [1:0] SEW_8  = 2'd0;
  localparam logic [1:0] SEW_16 = 2'd1;
  localparam logic [1:0] SEW_32 = 2'd2;
  localparam logic [1:0] SEW_64 = 2'd3;

  localparam logic [2:0] OP_EQ  = 3'd0;
  localparam logic [2:0] OP_NE  = 3'd1;
  localparam logic [2:0] OP_LTU = 3'd2;
  localparam logic [2:0] OP_LT  = 3'd3;
  localparam logic [2:0] OP_LEU = 3'd4;
  localparam logic [2:0] OP_LE  = 3'd5;
  localparam logic [2:0] OP_GTU = 3'd6;
  localparam logic [2:0] OP_GT  = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  // Number of SEW-wide elements carried by one DATA_WIDTH beat.
  function automatic int elems_per_beat(input logic [1:0] sew, input int data_width);
    return data_width >> (int'(sew) + 3);
  endfunction

endpackage

// File: rtl/vmcmp_lane.sv
// vmcmp_lane: combinational element-wise compare array.
// For every SEW it builds eq / unsigned-lt / signed-lt per element, with
// element k's result at bit k; the active SEW selects one set. Bits at or
// above the element count of the selected SEW are zero.
module vmcmp_lane #(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [1:0]            sew,
  output logic [DATA_WIDTH-1:0] eq,
  output logic [DATA_WIDTH-1:0] ltu,
  output logic [DATA_WIDTH-1:0] lt
);

  logic [3:0][DATA_WIDTH-1:0] eq_s;
  logic [3:0][DATA_WIDTH-1:0] ltu_s;
  logic [3:0][DATA_WIDTH-1:0] lt_s;

  for (genvar s = 0; s < 4; s++) begin : g_sew
    localparam int W = 8 << s;
    localparam int N = DATA_WIDTH / W;
    for (genvar k = 0; k < DATA_WIDTH; k++) begin : g_el
      if (k < N) begin : g_act
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        assign ea          = a[k*W +: W];
        assign eb          = b[k*W +: W];
        assign eq_s[s][k]  = (ea == eb);
        assign ltu_s[s][k] = (ea < eb);
        assign lt_s[s][k]  = ($signed(ea) < $signed(eb));
      end else begin : g_pad
        assign eq_s[s][k]  = 1'b0;
        assign ltu_s[s][k] = 1'b0;
        assign lt_s[s][k]  = 1'b0;
      end
    end
  end

  // select the compare set of the active element width
  always_comb begin
    eq  = eq_s[sew];
    ltu = ltu_s[sew];
    lt  = lt_s[sew];
  end

endmodule

// File: rtl/vmcmp_pack.sv
// vmcmp_pack: vector mask-compare with contiguous result packing.
// s0 registers the beat, s1 computes the per-element result bits, s2 packs
// them into a mask word under a two-state FSM, then a delay line of
// PIPE_STAGES+1 registers drives the writeback outputs.
// Build option: define VMCMP_PACK_MASK_EN to honour in_vm/in_mask; without
// it every element is active and those inputs are ignored.
// Handshake: in_valid qualifies a beat and is never refused; out_valid and
// out_drop are single-cycle pulses with no acknowledge.
module vmcmp_pack
  import vmcmp_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int BE_WIDTH    = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH  = 32,
  parameter int OPSEL_WIDTH = 3,
  parameter int PIPE_STAGES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [ADDR_WIDTH-1:0]  in_addr,
  input  logic [DATA_WIDTH-1:0]  in_vec0,
  input  logic [DATA_WIDTH-1:0]  in_vec1,
  input  logic [63:0]            in_scalar,
  input  logic                   in_use_scalar,
  input  logic [1:0]             in_sew,
  input  logic [OPSEL_WIDTH-1:0] in_opSel,
  input  logic                   in_req_start,
  input  logic                   in_req_end,
  input  logic                   in_vm,
  input  logic [BE_WIDTH-1:0]    in_mask,
  output logic                   out_valid,
  output logic [ADDR_WIDTH-1:0]  out_addr,
  output logic [DATA_WIDTH-1:0]  out_vec,
  output logic [BE_WIDTH-1:0]    out_be,
  output logic                   out_drop
);

  localparam int PTR_W = $clog2(DATA_WIDTH) + 1;
  localparam int DEPTH = PIPE_STAGES + 1;

  // ---------------- s0 ----------------
  logic [DATA_WIDTH-1:0]  b_sel;
  logic                   v0, start0, end0;
  logic [ADDR_WIDTH-1:0]  addr0;
  logic [DATA_WIDTH-1:0]  a0, b0;
  logic [1:0]             sew0;
  logic [OPSEL_WIDTH-1:0] op0;

  // operand B: vs1 or the scalar's low SEW bits replicated across the beat
  always_comb begin
    b_sel = in_vec1;
    if (in_use_scalar) begin
      case (in_sew)
        SEW_8:   b_sel = {(DATA_WIDTH/8){in_scalar[7:0]}};
        SEW_16:  b_sel = {(DATA_WIDTH/16){in_scalar[15:0]}};
        SEW_32:  b_sel = {(DATA_WIDTH/32){in_scalar[31:0]}};
        default: b_sel = {(DATA_WIDTH/64){in_scalar}};
      endcase
    end
  end

  // input register; everything is zeroed when the beat is not valid
  always_ff @(posedge clk) begin
    if (!rst) begin
      v0     <= 1'b0;
      start0 <= 1'b0;
      end0   <= 1'b0;
      addr0  <= '0;
      a0     <= '0;
      b0     <= '0;
      sew0   <= '0;
      op0    <= '0;
    end else begin
      v0     <= in_valid;
      start0 <= in_valid & in_req_start;
      end0   <= in_valid & in_req_end;
      addr0  <= in_valid ? in_addr : '0;
      a0     <= in_valid ? in_vec0 : '0;
      b0     <= in_valid ? b_sel : '0;
      sew0   <= in_valid ? in_sew : '0;
      op0    <= in_valid ? in_opSel : '0;
    end
  end

`ifdef VMCMP_PACK_MASK_EN
  logic                vm0;
  logic [BE_WIDTH-1:0] mask0;

  // mask controls travel with the beat; an invalid beat looks unmasked
  always_ff @(posedge clk) begin
    if (!rst) begin
      vm0   <= 1'b1;
      mask0 <= '0;
    end else begin
      vm0   <= in_valid ? in_vm : 1'b1;
      mask0 <= in_valid ? in_mask : '0;
    end
  end
`else
  logic unused_mask;
  assign unused_mask = ^{in_vm, in_mask};
`endif

  // ---------------- s1 ----------------
  logic [DATA_WIDTH-1:0] lane_eq, lane_ltu, lane_lt;
  logic [DATA_WIDTH-1:0] res, elem_mask;
  logic [PTR_W-1:0]      n0;

  vmcmp_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
    .a   (a0),
    .b   (b0),
    .sew (sew0),
    .eq  (lane_eq),
    .ltu (lane_ltu),
    .lt  (lane_lt)
  );

  // opcode select, mask-agnostic forcing, clear bits past the element count
  always_comb begin
    n0 = PTR_W'(elems_per_beat(sew0, DATA_WIDTH));
    for (int k = 0; k < DATA_WIDTH; k++) elem_mask[k] = (k < int'(n0));
    res = '0;
    case (op0)
      OP_EQ:   res = lane_eq;
      OP_NE:   res = ~lane_eq;
      OP_LTU:  res = lane_ltu;
      OP_LT:   res = lane_lt;
      OP_LEU:  res = lane_ltu | lane_eq;
      OP_LE:   res = lane_lt | lane_eq;
      OP_GTU:  res = ~(lane_ltu | lane_eq);
      default: res = ~(lane_lt | lane_eq);
    endcase
`ifdef VMCMP_PACK_MASK_EN
    if (!vm0) res = res | {{(DATA_WIDTH-BE_WIDTH){1'b0}}, ~mask0};
`endif
    res = res & elem_mask;
  end

  logic                  v1, start1, end1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] bits1;
  logic [PTR_W-1:0]      n1;

  // result register feeding the pack stage
  always_ff @(posedge clk) begin
    if (!rst) begin
      v1     <= 1'b0;
      start1 <= 1'b0;
      end1   <= 1'b0;
      addr1  <= '0;
      bits1  <= '0;
      n1     <= '0;
    end else begin
      v1     <= v0;
      start1 <= start0;
      end1   <= end0;
      addr1  <= addr0;
      bits1  <= res;
      n1     <= v0 ? n0 : '0;
    end
  end

  // ---------------- s2: pack ----------------
  state_t                state, state_nx;
  logic [PTR_W-1:0]      ptr;
  logic [DATA_WIDTH-1:0] acc;
  logic [ADDR_WIDTH-1:0] word_addr;

  logic                  new_word, drop, flush;
  logic [PTR_W-1:0]      base_ptr, end_ptr, nbytes;
  logic [DATA_WIDTH-1:0] merged;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [BE_WIDTH-1:0]   be_word;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // FSM next state: any flushing beat closes the word
  always_comb begin
    state_nx = state;
    if (v1) state_nx = flush ? IDLE : ACC;
  end

  // FSM outputs: word start/restart, bit placement, flush and byte enables
  always_comb begin
    new_word = (state == IDLE) || start1;
    drop     = v1 && (state == ACC) && start1;
    base_ptr = new_word ? '0 : ptr;
    cur_addr = new_word ? addr1 : word_addr;
    merged   = (new_word ? '0 : acc) | (bits1 << base_ptr);
    end_ptr  = base_ptr + n1;
    flush    = v1 && ((end_ptr == PTR_W'(DATA_WIDTH)) || end1);
    nbytes   = (end_ptr + PTR_W'(7)) >> 3;
    for (int i = 0; i < BE_WIDTH; i++) be_word[i] = (PTR_W'(i) < nbytes);
  end

  logic                  pk_valid, pk_drop;
  logic [ADDR_WIDTH-1:0] pk_addr;
  logic [DATA_WIDTH-1:0] pk_vec;
  logic [BE_WIDTH-1:0]   pk_be;

  // accumulator, pointer, word address and the packed-word register
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr       <= '0;
      acc       <= '0;
      word_addr <= '0;
      pk_valid  <= 1'b0;
      pk_drop   <= 1'b0;
      pk_addr   <= '0;
      pk_vec    <= '0;
      pk_be     <= '0;
    end else begin
      if (v1) begin
        ptr       <= flush ? '0 : end_ptr;
        acc       <= flush ? '0 : merged;
        word_addr <= cur_addr;
      end
      pk_valid <= flush;
      pk_drop  <= drop;
      pk_addr  <= flush ? cur_addr : '0;
      pk_vec   <= flush ? merged : '0;
      pk_be    <= flush ? be_word : '0;
    end
  end

  // ---------------- output delay line ----------------
  logic [DEPTH-1:0]                 dl_valid, dl_drop;
  logic [DEPTH-1:0][ADDR_WIDTH-1:0] dl_addr;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] dl_vec;
  logic [DEPTH-1:0][BE_WIDTH-1:0]   dl_be;

  // shift the packed word through PIPE_STAGES+1 registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      dl_valid <= '0;
      dl_drop  <= '0;
      dl_addr  <= '0;
      dl_vec   <= '0;
      dl_be    <= '0;
    end else begin
      dl_valid[0] <= pk_valid;
      dl_drop[0]  <= pk_drop;
      dl_addr[0]  <= pk_addr;
      dl_vec[0]   <= pk_vec;
      dl_be[0]    <= pk_be;
      for (int i = 1; i < DEPTH; i++) begin
        dl_valid[i] <= dl_valid[i-1];
        dl_drop[i]  <= dl_drop[i-1];
        dl_addr[i]  <= dl_addr[i-1];
        dl_vec[i]   <= dl_vec[i-1];
        dl_be[i]    <= dl_be[i-1];
      end
    end
  end

  assign out_valid = dl_valid[DEPTH-1];
  assign out_drop  = dl_drop[DEPTH-1];
  assign out_addr  = dl_addr[DEPTH-1];
  assign out_vec   = dl_vec[DEPTH-1];
  assign out_be    = dl_be[DEPTH-1];

endmodule

// File: tb/tb_vmcmp_pack.sv
// tb_vmcmp_pack: directed plus randomized bench for vmcmp_pack.
// A word-level model turns each beat into expected output events with a
// due cycle; a compare process checks every cycle against the queue.
module tb_vmcmp_pack;

  localparam int DW = 64;
  localparam int BW = 8;
  localparam int AW = 32;
  localparam int OW = 3;
  localparam int PS = 3;

`ifdef VMCMP_PACK_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          in_valid = 1'b0;
  logic [AW-1:0] in_addr = '0;
  logic [DW-1:0] in_vec0 = '0, in_vec1 = '0;
  logic [63:0]   in_scalar = '0;
  logic          in_use_scalar = 1'b0;
  logic [1:0]    in_sew = '0;
  logic [OW-1:0] in_opSel = '0;
  logic          in_req_start = 1'b0, in_req_end = 1'b0, in_vm = 1'b1;
  logic [BW-1:0] in_mask = '0;
  logic          out_valid, out_drop;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_vec;
  logic [BW-1:0] out_be;

  vmcmp_pack #(
    .DATA_WIDTH(DW), .BE_WIDTH(BW), .ADDR_WIDTH(AW), .OPSEL_WIDTH(OW), .PIPE_STAGES(PS)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr),
    .in_vec0(in_vec0), .in_vec1(in_vec1), .in_scalar(in_scalar),
    .in_use_scalar(in_use_scalar), .in_sew(in_sew), .in_opSel(in_opSel),
    .in_req_start(in_req_start), .in_req_end(in_req_end), .in_vm(in_vm),
    .in_mask(in_mask), .out_valid(out_valid), .out_addr(out_addr),
    .out_vec(out_vec), .out_be(out_be), .out_drop(out_drop)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    int            due;
    logic          valid;
    logic          drop;
    logic [AW-1:0] addr;
    logic [DW-1:0] vec;
    logic [BW-1:0] be;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic          m_in_word = 1'b0;
  int            m_ptr = 0;
  logic [DW-1:0] m_acc = '0;
  logic [AW-1:0] m_addr = '0;

  function automatic logic [63:0] beat_bits(input logic [1:0] sew, input logic [2:0] op,
      input logic [63:0] a, input logic [63:0] b, input logic [63:0] sc, input logic us,
      input logic vm, input logic [7:0] mk);
    int w, n;
    logic [63:0] em, ea, eb, res;
    longint sa, sb;
    logic r;
    w = 8 << sew;
    n = 64 / w;
    em = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    res = '0;
    for (int k = 0; k < n; k++) begin
      ea = (a >> (k * w)) & em;
      eb = us ? (sc & em) : ((b >> (k * w)) & em);
      sa = ea << (64 - w);
      sb = eb << (64 - w);
      case (op)
        3'd0:    r = (ea == eb);
        3'd1:    r = (ea != eb);
        3'd2:    r = (ea < eb);
        3'd3:    r = (sa < sb);
        3'd4:    r = (ea <= eb);
        3'd5:    r = (sa <= sb);
        3'd6:    r = (ea > eb);
        default: r = (sa > sb);
      endcase
      if (MASK_EN && !vm && !mk[k]) r = 1'b1;
      res[k] = r;
    end
    return res;
  endfunction

  function automatic exp_t last_exp();
    return exp_q[exp_q.size() - 1];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [1:0] sew, input logic [2:0] op, input logic [63:0] a,
      input logic [63:0] b, input logic [63:0] sc, input logic us, input logic st,
      input logic en, input logic vm, input logic [7:0] mk, input logic [31:0] addr);
    logic [63:0] bits;
    logic dr;
    int n, c;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1; in_addr = addr; in_vec0 = a; in_vec1 = b; in_scalar = sc;
    in_use_scalar = us; in_sew = sew; in_opSel = op; in_req_start = st;
    in_req_end = en; in_vm = vm; in_mask = mk;
    c = cyc;
    bits = beat_bits(sew, op, a, b, sc, us, vm, mk);
    n = DW >> (int'(sew) + 3);
    dr = 1'b0;
    if (m_in_word && st) begin
      dr = 1'b1;
      m_in_word = 1'b0;
    end
    if (!m_in_word) begin
      m_in_word = 1'b1;
      m_ptr = 0;
      m_acc = '0;
      m_addr = addr;
    end
    m_acc = m_acc | (bits << m_ptr);
    m_ptr = m_ptr + n;
    e.due = c + 4 + PS;
    e.drop = dr;
    if (m_ptr == DW || en) begin
      e.valid = 1'b1;
      e.addr = m_addr;
      e.vec = m_acc;
      e.be = BW'((1 << ((m_ptr + 7) / 8)) - 1);
      exp_q.push_back(e);
      m_in_word = 1'b0;
    end else if (dr) begin
      e.valid = 1'b0;
      e.addr = '0;
      e.vec = '0;
      e.be = '0;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_vec0 = {$urandom(), $urandom()};
      in_req_start = 1'($urandom_range(0, 1));
      in_req_end = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_reset(input int n);
    exp_t keep[$];
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    foreach (exp_q[i]) if (exp_q[i].due <= cyc) keep.push_back(exp_q[i]);
    exp_q = keep;
    m_in_word = 1'b0;
    m_ptr = 0;
    m_acc = '0;
    repeat (n) @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    exp_t e;
    logic ev, ed;
    ev = 1'b0;
    ed = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      ev = e.valid;
      ed = e.drop;
      if (ev) begin
        chk("out_addr", 64'(out_addr), 64'(e.addr));
        chk("out_vec", out_vec, e.vec);
        chk("out_be", 64'(out_be), 64'(e.be));
      end
    end
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("out_drop", 64'(out_drop), 64'(ed));
  end

  // ---------------- stimulus ----------------
  initial begin
    exp_t e;
    logic [1:0] sew;
    logic [63:0] a, b;
    logic [31:0] base;
    int nb;

    do_reset(4);
    idle(2);

    // single-beat byte compare, all equal
    send(2'd0, 3'd0, 64'h0102030405060708, 64'h0102030405060708, 64'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 32'h100);
    e = last_exp();
    chk("pin_eq8_vec", e.vec, 64'hFF);
    chk("pin_eq8_be", 64'(e.be), 64'h01);
    idle(3);

    // signed vs unsigned at SEW 64
    send(2'd3, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 32'h110);
    chk("pin_lt64", last_exp().vec, 64'h1);
    send(2'd3, 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 32'h118);
    chk("pin_ltu64", last_exp().vec, 64'h0);

    // eight SEW-32 beats, all true, one word of 16 bits
    for (int i = 0; i < 8; i++) begin
      a = {$urandom(), $urandom()};
      send(2'd2, 3'd0, a, a, 64'd0, 1'b0, i == 0, i == 7, 1'b1, 8'h00, 32'h200 + 32'(i * 8));
    end
    e = last_exp();
    chk("pin_sew32_vec", e.vec, 64'hFFFF);
    chk("pin_sew32_be", 64'(e.be), 64'h03);
    chk("pin_sew32_addr", 64'(e.addr), 64'h200);

    // eight byte beats fill the word; the ninth starts a fresh one
    for (int i = 0; i < 8; i++) begin
      a = {$urandom(), $urandom()};
      send(2'd0, 3'd0, a, a, 64'd0, 1'b0, i == 0, 1'b0, 1'b1, 8'h00, 32'h300 + 32'(i * 8));
    end
    e = last_exp();
    chk("pin_full_vec", e.vec, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("pin_full_be", 64'(e.be), 64'hFF);
    send(2'd0, 3'd0, 64'h0, 64'h0101010101010101, 64'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 32'h340);
    e = last_exp();
    chk("pin_ninth_vec", e.vec, 64'h0);
    chk("pin_ninth_be", 64'(e.be), 64'h01);
    chk("pin_ninth_addr", 64'(e.addr), 64'h340);

    // masked byte compare, every element unequal
    send(2'd0, 3'd0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h0F, 32'h400);
    chk("pin_mask_vec", last_exp().vec, MASK_EN ? 64'hF0 : 64'h00);
    idle(2);

    // restart inside a word: drop plus a single-beat word
    send(2'd1, 3'd1, 64'h1, 64'h2, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 32'h500);
    send(2'd1, 3'd0, 64'h5, 64'h5, 64'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 32'h600);
    e = last_exp();
    chk("pin_drop_flag", 64'(e.drop), 64'h1);
    chk("pin_drop_vec", e.vec, 64'hF);
    chk("pin_drop_addr", 64'(e.addr), 64'h600);
    idle(8);

    // reset right behind a flushing beat kills its output
    send(2'd0, 3'd0, 64'h7, 64'h7, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 32'h700);
    send(2'd0, 3'd0, 64'h7, 64'h7, 64'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 32'h708);
    do_reset(2);
    idle(12);
    chk("reset_purge", 64'(exp_q.size()), 64'd0);

    // randomized requests, scalar forms, masks, restarts, resets
    for (int r = 0; r < 300; r++) begin
      sew = 2'($urandom_range(0, 3));
      nb = $urandom_range(1, 10);
      base = $urandom() & 32'hFFFF_FFF8;
      for (int i = 0; i < nb; i++) begin
        a = {$urandom(), $urandom()};
        case ($urandom_range(0, 2))
          0: b = a;
          1: b = {$urandom(), $urandom()};
          default: b = a ^ (64'd1 << $urandom_range(0, 63));
        endcase
        send(sew, 3'($urandom_range(0, 7)), a, b, ($urandom_range(0, 1) == 1) ? a : b,
             1'($urandom_range(0, 1)), i == 0, (i == nb - 1) && ($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), base + 32'(i * 8));
        if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
      end
      if ($urandom_range(0, 39) == 0) do_reset(2);
    end

    idle(20);
    chk("drain", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vmcmp_pack.md
Name: vmcmp_pack

Overview:
- Parametrised successor mask-compare unit for the vALU.
- Compares two vector operands element-wise at SEW 8/16/32/64, or a vector against a broadcast scalar (.vx forms).
- Applies the v0 mask and packs the per-beat result bits contiguously into one mask word across multi-beat requests.
- Emits the word with byte enables to the writeback path after a configurable delay.

Parameters:
- DATA_WIDTH, 64, operand and result width in bits; power of 2, ≥64.
- BE_WIDTH, DATA_WIDTH/8, output byte-enable width.
- ADDR_WIDTH, 32, destination address width.
- OPSEL_WIDTH, 3, compare opcode width.
- PIPE_STAGES, 3, extra output register stages after the pack stage; 0 allowed.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  beat valid; no backpressure.
- in_addr  in  ADDR_WIDTH  destination address of the beat.
- in_vec0  in  DATA_WIDTH  operand A (vs2).
- in_vec1  in  DATA_WIDTH  operand B (vs1).
- in_scalar  in  64  scalar operand; low SEW bits are replicated to every element.
- in_use_scalar  in  1  selects in_scalar instead of in_vec1.
- in_sew  in  2  0=8, 1=16, 2=32, 3=64 bits.
- in_opSel  in  OPSEL_WIDTH  0 eq, 1 ne, 2 ltu, 3 lt, 4 leu, 5 le, 6 gtu, 7 gt.
- in_req_start  in  1  first beat of a request.
- in_req_end  in  1  last beat of a request.
- in_vm  in  1  1 = unmasked.
- in_mask  in  BE_WIDTH  v0 bits for this beat's elements, LSB-aligned.
- out_valid  out  1  packed word valid, one-cycle pulse.
- out_addr  out  ADDR_WIDTH  address captured from the first beat of the word.
- out_vec  out  DATA_WIDTH  packed mask word.
- out_be  out  BE_WIDTH  bytes written.
- out_drop  out  1  one-cycle pulse: partial word abandoned.

Behaviour:
- Reset: all outputs, pipeline registers and the FSM clear to 0 / IDLE. Reset mid-request discards all in-flight data and produces no output.
- Elements per beat: N = DATA_WIDTH >> (sew+3).
- Stage s0: register the inputs. Data is gated with in_valid.
- Stage s1: compute N result bits.
  - Signed compares use two's complement.
  - gt/gtu are defined as ~(le/leu).
  - Masked element (in_vm=0 and in_mask[k]=0): result bit forced to 1 (mask-agnostic).
  - Bits ≥N are zeroed.
- Stage s2 (pack): a bit pointer ptr (log2(DATA_WIDTH)+1 bits) places the N bits at acc[ptr+N-1:ptr], then ptr += N.
- FSM:
  - IDLE, ptr=0: a valid beat captures its address → ACC. If that beat also flushes, return to IDLE.
  - ACC: accumulates each valid beat.
  - Flush when ptr+N == DATA_WIDTH (word full, pointer wraps to 0) or in_req_end. On flush: emit acc, out_be = ceil((ptr+N)/8) LSB ones, ptr←0, →IDLE.
  - in_req_start while in ACC: abandon the partial word, pulse out_drop, then treat the beat as the first of a new word.
  - Simultaneous req_start & req_end: a single-beat word.
- in_sew changes only at a req_start. A SEW change mid-word is undefined.
- Latency: a flushing beat sampled at edge T gives out_valid at edge T+3+PIPE_STAGES.
- Throughput: one beat per cycle. Back-to-back flushes produce back-to-back out_valid.
- Idle cycles (in_valid=0) inside ACC hold state.

Optional Feature:
- Macro: VMCMP_PACK_MASK_EN.
- Defined: in_vm/in_mask are honoured as described above.
- Undefined: in_vm/in_mask are ignored and unused, every element is active, and the masking logic is not synthesised. Port list is unchanged.

Decomposition:
- Package vmcmp_pkg holds:
  - SEW encoding constants;
  - opSel constants (OP_EQ … OP_GT);
  - FSM state typedef {IDLE, ACC};
  - function elems_per_beat(sew, DATA_WIDTH).
- Sub-module vmcmp_lane: a combinational per-SEW compare array producing eq/ltu/lt vectors, instantiated once at s1. Packing, FSM and the delay line stay in the top level.

Test Plan:
- sew=0, opSel=eq, vec0=vec1=0x0102030405060708, start&end → out_vec=0xFF, out_be=0x01, out_valid at T+6 (PIPE_STAGES=3).
- sew=3, opSel=lt, vec0=0xFFFF_FFFF_FFFF_FFFF, vec1=0 → bit0=1; opSel=ltu on the same operands → bit0=0.
- sew=2, eight beats, each compare all-true, start on beat 0, end on beat 7 → one output out_vec=0xFFFF, out_be=0x03, out_addr = beat-0 address.
- sew=0, 8 beats without end → word full at ptr=64: out_vec all ones, out_be=0xFF; the ninth beat starts a new word at ptr 0.
- VMCMP_PACK_MASK_EN defined, sew=0, vm=0, in_mask=0x0F, eq false on all elements → out_vec=0xF0. Macro undefined → 0x00.
- Beat with start (no end), then a beat with start&end → out_drop pulse, then a single output for the second beat only. rst low mid-request → no out_valid afterwards.
